// File: rtl/counter_checker.sv
// Sequence checker for a free-running counter: learns the count stream, locks
// after LOCK_THRESH consecutive correct samples, then flags, counts and captures deviations.
module counter_checker #(
   parameter int WIDTH       = 12,
   parameter int LOCK_THRESH = 4
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             d_en,
   input  logic [WIDTH-1:0] d_in,
   output logic             locked,
   output logic             err_pulse,
   output logic [15:0]      err_count,
   output logic [7:0]       wrap_count,
   output logic [WIDTH-1:0] last_bad
);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_LOCK = 2'd2;

   localparam logic [3:0]       THRESH_M1 = 4'(LOCK_THRESH - 1);
   localparam logic [WIDTH-1:0] ALL_ONES  = '1;

   logic [1:0]       state_q, state_d;
   logic [3:0]       good_cnt_q, good_cnt_d;
   logic [WIDTH-1:0] prev_q;
   logic             en_q;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [7:0]       wrap_count_q, wrap_count_d;
   logic [WIDTH-1:0] last_bad_q, last_bad_d;

   logic [WIDTH-1:0] exp_val;
   logic             match;

   // The previous sample plus its enable predicts this cycle's value; the carry out of all-ones is dropped.
   always_comb begin
      exp_val = en_q ? (prev_q + WIDTH'(1)) : prev_q;
      match   = (d_in == exp_val);
   end

   always_comb begin
      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      err_pulse_d  = 1'b0;
      err_count_d  = err_count_q;
      wrap_count_d = wrap_count_q;
      last_bad_d   = last_bad_q;
      case (state_q)
         ST_INIT: begin
            state_d    = ST_SYNC;
            good_cnt_d = 4'd0;
         end
         ST_SYNC: begin
            if (!match) begin
               good_cnt_d = 4'd0;
            end else if (good_cnt_q == THRESH_M1) begin
               state_d    = ST_LOCK;
               good_cnt_d = 4'd0;
            end else begin
               good_cnt_d = good_cnt_q + 4'd1;
            end
         end
         ST_LOCK: begin
            if (match) begin
               if (en_q && (prev_q == ALL_ONES) && (wrap_count_q != 8'hFF)) begin
                  wrap_count_d = wrap_count_q + 8'd1;
               end
            end else begin
               // Leaving LOCK here is what keeps a burst of bad samples down to a single error.
               err_pulse_d = 1'b1;
               if (err_count_q != 16'hFFFF) begin
                  err_count_d = err_count_q + 16'd1;
               end
               last_bad_d = d_in;
               state_d    = ST_SYNC;
               good_cnt_d = 4'd0;
            end
         end
         default: begin
            state_d    = ST_INIT;
            good_cnt_d = 4'd0;
         end
      endcase
      locked_d = (state_d == ST_LOCK);
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q      <= ST_INIT;
         good_cnt_q   <= 4'd0;
         prev_q       <= '0;
         en_q         <= 1'b0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         err_count_q  <= 16'd0;
         wrap_count_q <= 8'd0;
         last_bad_q   <= '0;
      end else begin
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         prev_q       <= d_in;
         en_q         <= d_en;
         locked_q     <= locked_d;
         err_pulse_q  <= err_pulse_d;
         err_count_q  <= err_count_d;
         wrap_count_q <= wrap_count_d;
         last_bad_q   <= last_bad_d;
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign err_count  = err_count_q;
   assign wrap_count = wrap_count_q;
   assign last_bad   = last_bad_q;

endmodule
